// File: rtl/core_pkg.sv
// Shared types for the ID/EX stage: opcodes, ALU op encoding and the registered stage record.
package core_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'h0,
    ALU_SUB   = 4'h1,
    ALU_SLT   = 4'h2,
    ALU_SLTU  = 4'h3,
    ALU_XOR   = 4'h4,
    ALU_OR    = 4'h5,
    ALU_AND   = 4'h6,
    ALU_SLL   = 4'h7,
    ALU_SRL   = 4'h8,
    ALU_SRA   = 4'h9,
    ALU_PASSB = 4'hA
  } alu_op_e;

  typedef struct packed {
    logic        valid;
    logic        rd_wren;
    logic        is_load;
    logic        is_store;
    logic        is_branch;
    logic        is_jump;
    logic        illegal;
    logic        sel_a_pc;
    logic        sel_b_imm;
    alu_op_e     alu_op;
    logic [31:0] pc;
    logic [4:0]  rd_addr;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [2:0]  funct3;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
  } id_ex_t;

  // alt selects SUB/SRA; the caller masks it for OP-IMM where funct3=000 has no SUB form
  function automatic alu_op_e arith_op(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/fwd_mux.sv
// Per-source operand forwarding: EX/MEM beats MEM/WB, x0 is never forwarded.
module fwd_mux #(
  parameter int XLEN   = 32,
  parameter bit FWD_EN = 1'b1
) (
  input  logic [4:0]      rs_addr_i,
  input  logic [XLEN-1:0] rf_data_i,
  input  logic [4:0]      exm_rd_addr_i,
  input  logic            exm_rd_wren_i,
  input  logic [XLEN-1:0] exm_data_i,
  input  logic [4:0]      mwb_rd_addr_i,
  input  logic            mwb_rd_wren_i,
  input  logic [XLEN-1:0] mwb_data_i,
  output logic [XLEN-1:0] fwd_data_o
);

  always_comb begin
    fwd_data_o = rf_data_i;
    if (FWD_EN && (rs_addr_i != 5'd0)) begin
      if (exm_rd_wren_i && (exm_rd_addr_i == rs_addr_i)) begin
        fwd_data_o = exm_data_i;
      end else if (mwb_rd_wren_i && (mwb_rd_addr_i == rs_addr_i)) begin
        fwd_data_o = mwb_data_i;
      end
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with opcode decode, operand forwarding and load-use detection.
module id_ex_stage
  import core_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter bit FWD_EN = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic            id_valid_i,
  input  logic [XLEN-1:0] id_pc_i,
  input  logic [XLEN-1:0] id_rs1_data_i,
  input  logic [XLEN-1:0] id_rs2_data_i,
  input  logic [XLEN-1:0] id_imm_i,
  input  logic [4:0]      id_rs1_addr_i,
  input  logic [4:0]      id_rs2_addr_i,
  input  logic [4:0]      id_rd_addr_i,
  input  logic [6:0]      id_opcode_i,
  input  logic [2:0]      id_funct3_i,
  input  logic            id_funct7b5_i,
  input  logic [4:0]      exm_rd_addr_i,
  input  logic            exm_rd_wren_i,
  input  logic [XLEN-1:0] exm_data_i,
  input  logic [4:0]      mwb_rd_addr_i,
  input  logic            mwb_rd_wren_i,
  input  logic [XLEN-1:0] mwb_data_i,
  output logic [XLEN-1:0] operand_a_o,
  output logic [XLEN-1:0] operand_b_o,
  output logic [3:0]      alu_op_o,
  output logic [XLEN-1:0] rs2_fwd_o,
  output logic [XLEN-1:0] rs1_fwd_o,
  output logic [XLEN-1:0] pc_o,
  output logic [4:0]      rd_addr_o,
  output logic            rd_wren_o,
  output logic            valid_o,
  output logic [2:0]      funct3_o,
  output logic            is_load_o,
  output logic            is_store_o,
  output logic            is_branch_o,
  output logic            is_jump_o,
  output logic            illegal_o,
  output logic            load_use_o
);

  id_ex_t dec;
  id_ex_t stage_d;
  id_ex_t stage_q;
  logic   writes_rd;

  always_comb begin
    dec           = '0;
    writes_rd     = 1'b0;
    dec.valid     = id_valid_i;
    dec.pc        = id_pc_i;
    dec.rd_addr   = id_rd_addr_i;
    dec.rs1_addr  = id_rs1_addr_i;
    dec.rs2_addr  = id_rs2_addr_i;
    dec.funct3    = id_funct3_i;
    dec.rs1_data  = id_rs1_data_i;
    dec.rs2_data  = id_rs2_data_i;
    dec.imm       = id_imm_i;
    dec.alu_op    = ALU_ADD;
    case (id_opcode_i)
      OPC_OP: begin
        dec.alu_op = arith_op(id_funct3_i, id_funct7b5_i);
        writes_rd  = 1'b1;
      end
      OPC_OPIMM: begin
        dec.alu_op    = arith_op(id_funct3_i, id_funct7b5_i & (id_funct3_i != 3'b000));
        dec.sel_b_imm = 1'b1;
        writes_rd     = 1'b1;
      end
      OPC_LOAD: begin
        dec.is_load   = 1'b1;
        dec.sel_b_imm = 1'b1;
        writes_rd     = 1'b1;
      end
      OPC_STORE: begin
        dec.is_store  = 1'b1;
        dec.sel_b_imm = 1'b1;
      end
      OPC_JALR: begin
        dec.is_jump   = 1'b1;
        dec.sel_b_imm = 1'b1;
        writes_rd     = 1'b1;
      end
      OPC_JAL: begin
        dec.is_jump   = 1'b1;
        dec.sel_a_pc  = 1'b1;
        dec.sel_b_imm = 1'b1;
        writes_rd     = 1'b1;
      end
      OPC_AUIPC: begin
        dec.sel_a_pc  = 1'b1;
        dec.sel_b_imm = 1'b1;
        writes_rd     = 1'b1;
      end
      // branch target is computed on the ALU; the compare uses the forwarded rs values
      OPC_BRANCH: begin
        dec.is_branch = 1'b1;
        dec.sel_a_pc  = 1'b1;
        dec.sel_b_imm = 1'b1;
      end
      OPC_LUI: begin
        dec.alu_op    = ALU_PASSB;
        dec.sel_b_imm = 1'b1;
        writes_rd     = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
    dec.rd_wren = writes_rd & (id_rd_addr_i != 5'd0);
  end

  always_comb begin
    stage_d = stage_q;
    if (flush_i) begin
      stage_d = '0;
    end else if (!stall_i) begin
      stage_d = id_valid_i ? dec : '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  fwd_mux #(.XLEN(XLEN), .FWD_EN(FWD_EN)) u_fwd_rs1 (
    .rs_addr_i     (stage_q.rs1_addr),
    .rf_data_i     (stage_q.rs1_data),
    .exm_rd_addr_i (exm_rd_addr_i),
    .exm_rd_wren_i (exm_rd_wren_i),
    .exm_data_i    (exm_data_i),
    .mwb_rd_addr_i (mwb_rd_addr_i),
    .mwb_rd_wren_i (mwb_rd_wren_i),
    .mwb_data_i    (mwb_data_i),
    .fwd_data_o    (rs1_fwd_o)
  );

  fwd_mux #(.XLEN(XLEN), .FWD_EN(FWD_EN)) u_fwd_rs2 (
    .rs_addr_i     (stage_q.rs2_addr),
    .rf_data_i     (stage_q.rs2_data),
    .exm_rd_addr_i (exm_rd_addr_i),
    .exm_rd_wren_i (exm_rd_wren_i),
    .exm_data_i    (exm_data_i),
    .mwb_rd_addr_i (mwb_rd_addr_i),
    .mwb_rd_wren_i (mwb_rd_wren_i),
    .mwb_data_i    (mwb_data_i),
    .fwd_data_o    (rs2_fwd_o)
  );

  assign operand_a_o = stage_q.sel_a_pc  ? stage_q.pc  : rs1_fwd_o;
  assign operand_b_o = stage_q.sel_b_imm ? stage_q.imm : rs2_fwd_o;
  assign alu_op_o    = stage_q.alu_op;
  assign pc_o        = stage_q.pc;
  assign rd_addr_o   = stage_q.rd_addr;
  assign rd_wren_o   = stage_q.rd_wren;
  assign valid_o     = stage_q.valid;
  assign funct3_o    = stage_q.funct3;
  assign is_load_o   = stage_q.is_load;
  assign is_store_o  = stage_q.is_store;
  assign is_branch_o = stage_q.is_branch;
  assign is_jump_o   = stage_q.is_jump;
  assign illegal_o   = stage_q.illegal;

  assign load_use_o = valid_o & is_load_o & (rd_addr_o != 5'd0) & id_valid_i &
                      ((rd_addr_o == id_rs1_addr_i) | (rd_addr_o == id_rs2_addr_i));

endmodule
